spi_master_multi: RTL and testbench
===================================

# spi_master_multi

Parametrised SPI master, successor to the single-mode 8-bit master. Runs one full-duplex transfer of DATA_W bits per `start` pulse. SPI mode (CPOL/CPHA) and target slave are selected per transfer. Drives up to NUM_CS active-low chip selects. Sits between the fabric control logic and the board's SPI peripherals. It is the only block that toggles `spi_clk`.

## Interface
Parameters:
- DATA_W, 8: bits per transfer; must be ≥ 2.
- CLK_DIV, 4: SCK half-period H in `clk` cycles; must be ≥ 1.
- NUM_CS, 4: number of chip-select outputs.
- CS_SEL_W, 2: width of `cs_sel`; 2^CS_SEL_W ≥ NUM_CS.
- MSB_FIRST, 1: 1 = shift MSB first, 0 = LSB first (applies to both mosi and miso).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transfer; sampled only in IDLE.
- cpol  in  1  SCK idle level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- cs_sel  in  CS_SEL_W  slave index.
- data_wr  in  DATA_W  word to transmit.
- miso  in  1  serial data from slave.
- spi_clk  out  1  SCK.
- cs_n  out  NUM_CS  chip selects, active low.
- mosi  out  1  serial data to slave.
- data_rd  out  DATA_W  last received word.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- state  out  2  FSM state: IDLE=0, SETUP=1, TRANSFER=2, HOLD=3.

## Operation
- **Reset:** state IDLE, `spi_clk`=0, `cs_n`=all 1, `mosi`=0, `data_rd`=0, `busy`=0, `done`=0, all counters and shift registers 0.
- **IDLE:**
  - `spi_clk` loads `cpol` every cycle.
  - `cs_n` is all 1; `mosi` holds its last value.
  - `start`=1 latches `data_wr`, `cpol`, `cpha` and `cs_sel` into internal registers, then moves to SETUP.
- **SETUP (H cycles):**
  - `cs_n[cs_sel_q]`=0; `busy`=1.
  - If cpha_q=0, `mosi` drives the first bit on SETUP entry.
- **TRANSFER:**
  - 2·DATA_W SCK edges, one every H cycles; odd-numbered edges are leading, even-numbered are trailing.
  - cpha_q=0: sample `miso` on leading edges; shift the next bit onto `mosi` on trailing edges, except after the final edge.
  - cpha_q=1: shift a bit onto `mosi` on leading edges (the first bit at edge 1); sample `miso` on trailing edges.
  - "Sample" means `miso` is captured on the same `clk` edge that registers the SCK toggle.
- **HOLD (H cycles after the last edge):**
  - `spi_clk` stays at cpol_q; the selected `cs_n` stays low.
  - On exit: `data_rd` ← received word, `cs_n` all 1, `busy`=0, `done`=1 for one cycle, state IDLE.
- **Bit order:** MSB_FIRST=1 sends `data_wr[DATA_W-1]` first, and the first received bit lands in `data_rd[DATA_W-1]`. MSB_FIRST=0 mirrors this.
- **Input changes while busy:** `start`, `cpol`, `cpha`, `cs_sel` and `data_wr` are ignored; no queuing.
- **Out-of-range `cs_sel` (≥ NUM_CS):** the transfer runs normally and `done` pulses, but no `cs_n` bit is asserted.
- **Reset mid-transfer:** all outputs return to reset values on the next `clk` edge. No `done` pulse; `data_rd` is cleared.

## Timing
- Take T0 as the `clk` edge where `start` is sampled in IDLE.
- T0+1: state=SETUP, `busy`=1, selected `cs_n`=0.
- SCK edge k (k=1..2·DATA_W) is visible at T0+1+k·H.
- Completion at T0+1+(2·DATA_W+1)·H: state=IDLE, `done`=1, `busy`=0, `cs_n` all 1, `data_rd` valid.
  - With DATA_W=8, H=4: completion at T0+69.
  - Start-to-done latency is (2·DATA_W+1)·H+1 cycles.
- `data_rd` holds its value until the next completion or reset.
- **Back-to-back:** `start`=1 during the `done` cycle is accepted (that cycle is IDLE). The next SETUP begins one cycle later, giving a minimum `cs_n` high time of 1 `clk` cycle.
- **CLK_DIV=1:** SCK toggles every cycle; the same ordering rules apply.

## Test plan
- Mode 0, DATA_W=8, H=4, `mosi` looped to `miso`, `data_wr`=0xAB, `cs_sel`=0 -> `done` at T0+69, `data_rd`=0xAB, `cs_n`=4'b1110 for cycles T0+1..T0+68, and exactly 8 rising SCK edges.
- Mode 3 (cpol=1, cpha=1), slave model drives 0x5C on falling SCK edges, `data_wr`=0x3A -> `spi_clk` idles high, slave captures 0x3A on rising edges, `data_rd`=0x5C.
- Modes 1 and 2 with MSB_FIRST=0, `data_wr`=0x01 -> first `mosi` bit is 1, followed by seven 0s; loopback gives `data_rd`=0x01.
- `cs_sel`=2, then `cs_sel`=5 with NUM_CS=4 -> only `cs_n[2]` goes low; for `cs_sel`=5 `cs_n` stays 4'b1111 and `done` still pulses.
- `start` re-asserted at T0+10 and `data_wr` changed mid-transfer -> ignored: one `done`, `data_rd` reflects the original word.
- `reset` at T0+30 -> next cycle `state`=0, `cs_n` all 1, `spi_clk`=0, `data_rd`=0, and no `done`. Then `start` held high through `done` -> the second transfer starts with `cs_n` high for exactly 1 cycle.

Source files
------------

// File: rtl/spi_master_multi.sv
// spi_master_multi: full-duplex SPI master, one DATA_W-bit transfer per start pulse.
// CPOL/CPHA and the target slave are latched per transfer; the block owns spi_clk.
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   reset    in   synchronous active-high reset
//   start    in   request a transfer (only looked at in IDLE)
//   cpol     in   SCK idle level for the next transfer
//   cpha     in   0 = sample on leading edge, 1 = sample on trailing edge
//   cs_sel   in   slave index; values >= NUM_CS run with no chip select asserted
//   data_wr  in   word to transmit
//   miso     in   serial data from slave
//   spi_clk  out  SCK
//   cs_n     out  active-low chip selects
//   mosi     out  serial data to slave
//   data_rd  out  last received word, held until next completion or reset
//   busy     out  transfer in progress
//   done     out  one-cycle completion pulse
//   state    out  FSM state: IDLE=0, SETUP=1, TRANSFER=2, HOLD=3
module spi_master_multi #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned NUM_CS    = 4,
   parameter int unsigned CS_SEL_W  = 2,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                cpol,
   input  logic                cpha,
   input  logic [CS_SEL_W-1:0] cs_sel,
   input  logic [DATA_W-1:0]   data_wr,
   input  logic                miso,
   output logic                spi_clk,
   output logic [NUM_CS-1:0]   cs_n,
   output logic                mosi,
   output logic [DATA_W-1:0]   data_rd,
   output logic                busy,
   output logic                done,
   output logic [1:0]          state
);

   localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);
   localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
   localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StSetup    = 2'd1,
      StTransfer = 2'd2,
      StHold     = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [DivW-1:0]    div_cnt_q, div_cnt_d;
   logic [EdgeW-1:0]   edge_cnt_q, edge_cnt_d;
   logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
   logic               cpol_q, cpol_d;
   logic               cpha_q, cpha_d;
   logic               spi_clk_q, spi_clk_d;
   logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
   logic               mosi_q, mosi_d;
   logic [DATA_W-1:0]  data_rd_q, data_rd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               div_last;
   logic               do_edge;
   logic               edge_lead;

   // Bit that goes out first / next, and the register after removing it.
   function automatic logic tx_bit(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   assign div_last  = (div_cnt_q == DivLast);
   // Edge number k = edge_cnt_q + 1; odd k is a leading edge.
   assign edge_lead = ~edge_cnt_q[0];

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      edge_cnt_d = edge_cnt_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      spi_clk_d  = spi_clk_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;
      data_rd_d  = data_rd_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      do_edge    = 1'b0;

      unique case (state_q)
         StIdle: begin
            spi_clk_d = cpol;
            cs_n_d    = '1;
            busy_d    = 1'b0;
            if (start) begin
               state_d    = StSetup;
               div_cnt_d  = '0;
               edge_cnt_d = '0;
               rx_sh_d    = '0;
               cpol_d     = cpol;
               cpha_d     = cpha;
               busy_d     = 1'b1;
               // Out-of-range indices match no bit, so every cs_n stays high.
               for (int i = 0; i < NUM_CS; i++) begin
                  cs_n_d[i] = (32'(cs_sel) != 32'(i));
               end
               if (!cpha) begin
                  mosi_d  = tx_bit(data_wr);
                  tx_sh_d = tx_shift(data_wr);
               end else begin
                  tx_sh_d = data_wr;
               end
            end
         end
         StSetup: begin
            if (div_last) begin
               div_cnt_d = '0;
               do_edge   = 1'b1;
               state_d   = StTransfer;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         StTransfer: begin
            if (div_last) begin
               div_cnt_d = '0;
               do_edge   = 1'b1;
               if (edge_cnt_q == EdgeLast) begin
                  state_d = StHold;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         StHold: begin
            spi_clk_d = cpol_q;
            if (div_last) begin
               div_cnt_d = '0;
               data_rd_d = rx_sh_q;
               cs_n_d    = '1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = StIdle;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (do_edge) begin
         edge_cnt_d = edge_cnt_q + 1'b1;
         spi_clk_d  = ~spi_clk_q;
         if (edge_lead ^ cpha_q) begin
            // Sample edge: leading for CPHA=0, trailing for CPHA=1.
            rx_sh_d = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], miso}
                                       : {miso, rx_sh_q[DATA_W-1:1]};
         end else if (edge_cnt_q != EdgeLast) begin
            // Final edge (CPHA=0 trailing) would shift past the last bit.
            mosi_d  = tx_bit(tx_sh_q);
            tx_sh_d = tx_shift(tx_sh_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         spi_clk_q  <= 1'b0;
         cs_n_q     <= '1;
         mosi_q     <= 1'b0;
         data_rd_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         spi_clk_q  <= spi_clk_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         data_rd_q  <= data_rd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign spi_clk = spi_clk_q;
   assign cs_n    = cs_n_q;
   assign mosi    = mosi_q;
   assign data_rd = data_rd_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign state   = state_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a table of per-mode transfers on an 8-bit, H=4 master with a
// small SPI slave model, plus hand-written sequences for mid-transfer input changes, reset,
// back-to-back starts, and an LSB-first H=1 instance.
module tb_spi_master_multi;

   localparam int Lat  = (2 * 8 + 1) * 4 + 1;  // 69
   localparam int Lat2 = (2 * 8 + 1) * 1 + 1;  // 18

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   // Main instance: MSB first, H=4, 3-bit cs_sel so index 5 is expressible.
   logic       start = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic [2:0] cs_sel = 3'd0;
   logic [7:0] data_wr = 8'h00;
   logic       miso;
   logic       spi_clk, mosi, busy, done;
   logic [3:0] cs_n;
   logic [7:0] data_rd;
   logic [1:0] state;

   // Second instance: LSB first, H=1, loopback.
   logic       start2 = 1'b0, cpol2 = 1'b0, cpha2 = 1'b0;
   logic [1:0] cs_sel2 = 2'd0;
   logic [7:0] data_wr2 = 8'h00;
   logic       spi_clk2, mosi2, busy2, done2;
   logic [3:0] cs_n2;
   logic [7:0] data_rd2;
   logic [1:0] state2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spi_master_multi #(
      .DATA_W(8), .CLK_DIV(4), .NUM_CS(4), .CS_SEL_W(3), .MSB_FIRST(1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel),
      .data_wr(data_wr), .miso(miso), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi),
      .data_rd(data_rd), .busy(busy), .done(done), .state(state)
   );

   spi_master_multi #(
      .DATA_W(8), .CLK_DIV(1), .NUM_CS(4), .CS_SEL_W(2), .MSB_FIRST(0)
   ) dut2 (
      .clk(clk), .reset(reset), .start(start2), .cpol(cpol2), .cpha(cpha2), .cs_sel(cs_sel2),
      .data_wr(data_wr2), .miso(mosi2), .spi_clk(spi_clk2), .cs_n(cs_n2), .mosi(mosi2),
      .data_rd(data_rd2), .busy(busy2), .done(done2), .state(state2)
   );

   // Slave model for the main instance (MSB first), evaluated away from the active edge.
   logic       loop_en = 1'b1;
   logic       mode_cpol = 1'b0, mode_cpha = 1'b0;
   logic [7:0] sl_word = 8'h00;
   logic [7:0] sl_tx = 8'h00, sl_rx = 8'h00;
   logic       sl_miso = 1'b0, sl_active = 1'b0, sl_prev = 1'b0;

   assign miso = loop_en ? mosi : sl_miso;

   always @(negedge clk) begin
      if (cs_n == 4'hF) begin
         sl_active = 1'b0;
         sl_prev   = spi_clk;
      end else if (!sl_active) begin
         sl_active = 1'b1;
         sl_tx     = sl_word;
         sl_rx     = 8'h00;
         sl_prev   = spi_clk;
         if (!mode_cpha) begin
            sl_miso = sl_tx[7];
            sl_tx   = {sl_tx[6:0], 1'b0};
         end
      end else if (spi_clk != sl_prev) begin
         if ((spi_clk != mode_cpol) ^ mode_cpha) begin
            sl_rx = {sl_rx[6:0], mosi};
         end else begin
            sl_miso = sl_tx[7];
            sl_tx   = {sl_tx[6:0], 1'b0};
         end
         sl_prev = spi_clk;
      end
   end

   typedef struct {
      logic       cpol;
      logic       cpha;
      logic [2:0] cs_sel;
      logic [7:0] wr;
      logic [7:0] slave;
      logic       loop;
      logic [7:0] exp_rd;
      logic [3:0] exp_cs;
      logic       chk_srx;
      logic [7:0] exp_srx;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One transfer on the main instance; inject_at > 0 pokes start/data_wr/cpha/cs_sel then.
   task automatic run_xfer(input vec_t v, input int inject_at);
      int   done_cnt = 0, done_idx = 0, rises = 0, cs_bad = 0, busy_bad = 0;
      logic prev;
      @(negedge clk);
      cpol      = v.cpol;
      cpha      = v.cpha;
      cs_sel    = v.cs_sel;
      data_wr   = v.wr;
      mode_cpol = v.cpol;
      mode_cpha = v.cpha;
      sl_word   = v.slave;
      loop_en   = v.loop;
      @(negedge clk);
      chk("idle_sck", 32'(spi_clk), 32'(v.cpol));
      prev  = spi_clk;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int idx = 1; idx <= Lat + 12; idx++) begin
         if (inject_at > 0 && idx == inject_at) begin
            start   = 1'b1;
            data_wr = ~v.wr;
            cpha    = ~v.cpha;
            cs_sel  = 3'd3;
         end
         if (inject_at > 0 && idx == inject_at + 1) begin
            start  = 1'b0;
            cpha   = v.cpha;
            cs_sel = v.cs_sel;
         end
         if (done) begin
            done_cnt++;
            if (done_idx == 0) begin
               done_idx = idx;
               chk("done_busy", 32'(busy), 32'd0);
               chk("done_cs_n", 32'(cs_n), 32'hF);
               chk("done_state", 32'(state), 32'd0);
               chk("data_rd", 32'(data_rd), 32'(v.exp_rd));
            end
         end
         if (done_idx == 0) begin
            if (spi_clk && !prev) rises++;
            if (cs_n != v.exp_cs) cs_bad++;
            if (!busy) busy_bad++;
         end
         prev = spi_clk;
         @(negedge clk);
      end
      chk("done_latency", 32'(done_idx), 32'(Lat));
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("sck_rises", 32'(rises), 32'd8);
      chk("cs_n_during", 32'(cs_bad), 32'd0);
      chk("busy_during", 32'(busy_bad), 32'd0);
      if (v.chk_srx) chk("slave_rx", 32'(sl_rx), 32'(v.exp_srx));
   endtask

   // LSB-first, H=1 loopback transfer of 0x01 on the second instance.
   task automatic run_lsb(input logic m_cpol, input logic m_cpha);
      int         done_idx = 0, nb = 0;
      logic [7:0] bits = 8'h00;
      logic       prev;
      @(negedge clk);
      cpol2    = m_cpol;
      cpha2    = m_cpha;
      data_wr2 = 8'h01;
      @(negedge clk);
      chk("lsb_idle_sck", 32'(spi_clk2), 32'(m_cpol));
      prev   = spi_clk2;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("lsb_busy", 32'(busy2), 32'd1);
      chk("lsb_cs_n", 32'(cs_n2), 32'hE);
      for (int idx = 1; idx <= Lat2 + 6; idx++) begin
         if (done2 && done_idx == 0) begin
            done_idx = idx;
            chk("lsb_data_rd", 32'(data_rd2), 32'h01);
            chk("lsb_state", 32'(state2), 32'd0);
         end
         if (done_idx == 0 && spi_clk2 != prev) begin
            // Record mosi as the slave would see it on each sample edge.
            if ((spi_clk2 != m_cpol) ^ m_cpha) begin
               if (nb < 8) bits[nb] = mosi2;
               nb++;
            end
         end
         prev = spi_clk2;
         @(negedge clk);
      end
      chk("lsb_latency", 32'(done_idx), 32'(Lat2));
      chk("lsb_nsamples", 32'(nb), 32'd8);
      chk("lsb_mosi_bits", 32'(bits), 32'h01);
   endtask

   initial begin
      int dcnt;
      vecs[0] = '{1'b0, 1'b0, 3'd0, 8'hAB, 8'h00, 1'b1, 8'hAB, 4'hE, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 3'd1, 8'h3A, 8'h5C, 1'b0, 8'h5C, 4'hD, 1'b1, 8'h3A};
      vecs[2] = '{1'b0, 1'b1, 3'd2, 8'hC3, 8'h96, 1'b0, 8'h96, 4'hB, 1'b1, 8'hC3};
      vecs[3] = '{1'b1, 1'b0, 3'd3, 8'h7E, 8'h81, 1'b0, 8'h81, 4'h7, 1'b1, 8'h7E};
      vecs[4] = '{1'b0, 1'b0, 3'd5, 8'h5A, 8'h00, 1'b1, 8'h5A, 4'hF, 1'b0, 8'h00};
      vecs[5] = '{1'b0, 1'b0, 3'd2, 8'h00, 8'hFF, 1'b0, 8'hFF, 4'hB, 1'b1, 8'h00};

      // Reset state; cpol=1 shows that reset wins over the idle-level load.
      cpol = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_sck", 32'(spi_clk), 32'd0);
      chk("rst_cs_n", 32'(cs_n), 32'hF);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_data_rd", 32'(data_rd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_xfer(vecs[i], 0);

      // start/data_wr/cpha/cs_sel disturbed at T0+10 must not affect the transfer.
      run_xfer('{1'b0, 1'b0, 3'd0, 8'h3C, 8'h00, 1'b1, 8'h3C, 4'hE, 1'b0, 8'h00}, 10);

      // Reset at T0+30 aborts the transfer without a done pulse.
      @(negedge clk);
      cpol = 1'b0; cpha = 1'b0; cs_sel = 3'd1; data_wr = 8'h55;
      mode_cpol = 1'b0; mode_cpha = 1'b0; loop_en = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_cs_n", 32'(cs_n), 32'hF);
      chk("abort_sck", 32'(spi_clk), 32'd0);
      chk("abort_data_rd", 32'(data_rd), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      dcnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);

      // start held high through done: second transfer follows with cs_n high one cycle.
      cs_sel = 3'd0; data_wr = 8'h96;
      start = 1'b1;
      @(negedge clk);
      dcnt = 0;
      for (int idx = 1; idx <= 145; idx++) begin
         if (done) dcnt++;
         if (idx == 30) data_wr = 8'h69;
         if (idx == 68) chk("b2b_cs_68", 32'(cs_n), 32'hE);
         if (idx == 69) begin
            chk("b2b_cs_69", 32'(cs_n), 32'hF);
            chk("b2b_done_1", 32'(done), 32'd1);
            chk("b2b_rd_1", 32'(data_rd), 32'h96);
         end
         if (idx == 70) begin
            chk("b2b_cs_70", 32'(cs_n), 32'hE);
            chk("b2b_busy_70", 32'(busy), 32'd1);
            start = 1'b0;
         end
         if (idx == 138) begin
            chk("b2b_done_2", 32'(done), 32'd1);
            chk("b2b_rd_2", 32'(data_rd), 32'h69);
         end
         @(negedge clk);
      end
      chk("b2b_done_count", 32'(dcnt), 32'd2);

      // LSB first, SCK every clk: modes 1 and 2.
      run_lsb(1'b0, 1'b1);
      run_lsb(1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
